exp_timer_ctrl: RTL
===================

EXP_TIMER_CTRL -- requirements
Module: exp_timer_ctrl

Interface
REQ-001 SHALL have parameter EXP_W, default 5, width of exposure setting and remaining counter.
REQ-002 SHALL have parameter EXP_MIN, default 2, lowest selectable exposure in units.
REQ-003 SHALL have parameter EXP_MAX, default 30, highest selectable exposure in units.
REQ-004 SHALL have parameter EXP_INIT, default 5, exposure loaded at reset.
REQ-005 SHALL have parameter TICK_DIV, default 4, Clk cycles per exposure unit.
REQ-006 SHALL have port Clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port Exp_Increase  input  1  level from button, rising edge steps up.
REQ-009 SHALL have port Exp_Decrease  input  1  level from button, rising edge steps down.
REQ-010 SHALL have port Exp_Start  input  1  exposure request, sampled in IDLE only.
REQ-011 SHALL have port Exp_Time  output  EXP_W  current exposure setting in units.
REQ-012 SHALL have port Exp_Busy  output  1  high in CLEAR and EXPOSE.
REQ-013 SHALL have port Exp_Done  output  1  one-cycle pulse at exposure end.
REQ-014 SHALL have port Counter_Clk  output  1  one-cycle pulse per elapsed exposure unit.
REQ-015 SHALL have port Counter_Reset  output  1  one-cycle pulse clearing the external counter at exposure start.

Function
REQ-016 SHALL detect rising edges of Exp_Increase/Exp_Decrease via one registered previous-value flop each; held level yields exactly one step.
REQ-017 SHALL update Exp_Time the cycle after a detected edge: +1 on increase, -1 on decrease.
REQ-018 SHALL saturate Exp_Time at EXP_MAX on increase and EXP_MIN on decrease; no wrap-around.
REQ-019 SHALL leave Exp_Time unchanged when both edges occur in the same cycle.
REQ-020 SHALL ignore adjustment edges while state is not IDLE; Exp_Time frozen during exposure, edges discarded, not queued.
REQ-021 SHALL implement FSM states IDLE, CLEAR, EXPOSE, DONE.
REQ-022 IDLE: Exp_Start=1 -> CLEAR; else stay.
REQ-023 CLEAR: one cycle; Counter_Reset=1; load remaining=Exp_Time, prescaler=0; -> EXPOSE.
REQ-024 EXPOSE: prescaler counts 0..TICK_DIV-1 and wraps; Counter_Clk=1 in cycles where prescaler=TICK_DIV-1; remaining decrements on those cycles; tick with remaining=1 -> DONE.
REQ-025 DONE: one cycle; Exp_Done=1; -> IDLE; Exp_Start ignored in this cycle.
REQ-026 Latency: Exp_Start sampled at cycle N gives Counter_Reset at N+1, Counter_Clk at N+1+k*TICK_DIV for k=1..Exp_Time, Exp_Done at N+2+Exp_Time*TICK_DIV.
REQ-027 Exp_Start held high SHALL retrigger a new exposure on the first IDLE cycle after DONE.
REQ-028 Exp_Start while Busy or in DONE SHALL be ignored.
REQ-029 Prescaler width SHALL be max(1, clog2(TICK_DIV)); TICK_DIV=1 gives Counter_Clk every EXPOSE cycle.
REQ-030 Parameters SHALL satisfy 1<=EXP_MIN<=EXP_INIT<=EXP_MAX<=2^EXP_W-1 and TICK_DIV>=1; violation halts elaboration.

Reset
REQ-031 Reset SHALL set state=IDLE, Exp_Time=EXP_INIT, remaining=0, prescaler=0.
REQ-032 Reset SHALL drive Exp_Busy, Exp_Done, Counter_Clk, Counter_Reset to 0.
REQ-033 Reset SHALL clear edge-detect flops to 0; a button held through reset produces one step on the first cycle after reset.
REQ-034 Reset mid-exposure SHALL abort to IDLE with no Exp_Done pulse.

Structure
REQ-035 State encoding constants (IDLE=0, CLEAR=1, EXPOSE=2, DONE=3) SHALL live in shared package exp_ctrl_pkg.
REQ-036 Prescaler and tick decode SHALL be sub-module exp_tick_gen (params TICK_DIV; ports Clk, Reset, Enable, Tick).

Verification (defaults unless stated)
REQ-037 Reset -> Exp_Time=5, Exp_Busy=0, all pulses 0.
REQ-038 Two 1-cycle Exp_Increase pulses, then Exp_Increase held 10 cycles -> Exp_Time 6, 7, then 8 only.
REQ-039 30 increase edges from 5 -> Exp_Time=30; 40 decrease edges -> Exp_Time=2; simultaneous inc/dec edge -> unchanged.
REQ-040 Exp_Time=2, Exp_Start at N -> Counter_Reset at N+1, Counter_Clk at N+5 and N+9, Exp_Done at N+10, Exp_Busy N+1..N+9.
REQ-041 Exp_Increase edge during EXPOSE -> Exp_Time unchanged after Exp_Done; Exp_Start held -> next Counter_Reset at N+12.
REQ-042 Reset at N+6 of REQ-040 run -> IDLE at N+7, no Exp_Done, Exp_Time=5.

Source files
------------

// File: rtl/exp_ctrl_pkg.sv
// Shared definitions for the exposure timer: FSM state encodings and the
// saturating exposure-step rule used by the adjustment logic.
package exp_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_EXPOSE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Opposing edges in the same cycle cancel; steps never cross lo/hi.
  function automatic int unsigned exp_adjust(input int unsigned cur,
                                             input logic        up,
                                             input logic        dn,
                                             input int unsigned lo,
                                             input int unsigned hi);
    int unsigned nxt;
    nxt = cur;
    if (up && !dn && (cur < hi)) begin
      nxt = cur + 32'd1;
    end else if (dn && !up && (cur > lo)) begin
      nxt = cur - 32'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/exp_tick_gen.sv
// Exposure-unit prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// last count of each unit. Held at zero whenever disabled.
module exp_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Enable,
  output logic Tick
);

  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next prescaler count
  always_comb begin
    cnt_d = '0;
    if (Enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // prescaler register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Tick = Enable && (cnt_q == LAST);

endmodule

// File: rtl/exp_timer_ctrl.sv
// Exposure timer controller: button-adjustable exposure setting and an
// IDLE/CLEAR/EXPOSE/DONE sequencer driving an external unit counter.
module exp_timer_ctrl
  import exp_ctrl_pkg::*;
#(
  parameter int unsigned EXP_W    = 5,
  parameter int unsigned EXP_MIN  = 2,
  parameter int unsigned EXP_MAX  = 30,
  parameter int unsigned EXP_INIT = 5,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Exp_Increase,
  input  logic             Exp_Decrease,
  input  logic             Exp_Start,
  output logic [EXP_W-1:0] Exp_Time,
  output logic             Exp_Busy,
  output logic             Exp_Done,
  output logic             Counter_Clk,
  output logic             Counter_Reset
);

  if (!((EXP_MIN >= 32'd1) && (EXP_MIN <= EXP_INIT) && (EXP_INIT <= EXP_MAX) &&
        (64'(EXP_MAX) < (64'd1 << EXP_W)) && (TICK_DIV >= 32'd1))) begin : g_bad_params
    $fatal(1, "exp_timer_ctrl: illegal parameter combination");
  end

  logic [1:0]       state_q, state_d;
  logic [EXP_W-1:0] exp_time_q, exp_time_d;
  logic [EXP_W-1:0] remaining_q, remaining_d;
  logic             inc_prev_q, dec_prev_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             crst_q, crst_d;
  logic             inc_edge_s, dec_edge_s;
  logic             expose_s, tick_s;

  assign inc_edge_s = Exp_Increase & ~inc_prev_q;
  assign dec_edge_s = Exp_Decrease & ~dec_prev_q;
  assign expose_s   = (state_q == ST_EXPOSE);

  exp_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .Clk    (Clk),
    .Reset  (Reset),
    .Enable (expose_s),
    .Tick   (tick_s)
  );

  // sequencer next state, setting adjustment and remaining-unit countdown
  always_comb begin
    state_d     = state_q;
    exp_time_d  = exp_time_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        exp_time_d = EXP_W'(exp_adjust(32'(exp_time_q), inc_edge_s, dec_edge_s,
                                       EXP_MIN, EXP_MAX));
        if (Exp_Start) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        remaining_d = exp_time_q;
        state_d     = ST_EXPOSE;
      end
      ST_EXPOSE: begin
        if (tick_s) begin
          remaining_d = remaining_q - EXP_W'(1);
          if (remaining_q == EXP_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXPOSE;
          end
        end else begin
          state_d = ST_EXPOSE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // status outputs are registered from the upcoming state
  always_comb begin
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_EXPOSE);
    done_d = (state_d == ST_DONE);
    crst_d = (state_d == ST_CLEAR);
  end

  // state, setting, edge-detect and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      exp_time_q  <= EXP_W'(EXP_INIT);
      remaining_q <= '0;
      inc_prev_q  <= 1'b0;
      dec_prev_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      crst_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_time_q  <= exp_time_d;
      remaining_q <= remaining_d;
      inc_prev_q  <= Exp_Increase;
      dec_prev_q  <= Exp_Decrease;
      busy_q      <= busy_d;
      done_q      <= done_d;
      crst_q      <= crst_d;
    end
  end

  assign Exp_Time      = exp_time_q;
  assign Exp_Busy      = busy_q;
  assign Exp_Done      = done_q;
  assign Counter_Reset = crst_q;
  assign Counter_Clk   = tick_s;

endmodule
